ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
Parametrised successor to the single-cycle fetch stage. Generates fetch addresses, issues them over a valid/ready request channel to an instruction memory with variable latency, and tracks up to MAX_OUTSTANDING in-order requests. Returned instructions are buffered in a prefetch FIFO and delivered to decode over a valid/ready handshake. Flush and branch redirect discard stale in-flight responses without stalling the memory side.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction word width
FIFO_DEPTH, 4, prefetch buffer entries; power of two, >= 2
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; 1..FIFO_DEPTH
REBOOT_ADDR, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock
n_rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  pipeline flush from ctrl; highest priority
new_pc_i  in  ADDR_W  flush target
branch_redirect_i  in  1  mispredict redirect from exu
branch_redirect_pc_i  in  ADDR_W  redirect target
req_valid_o  out  1  fetch request valid
req_addr_o  out  ADDR_W  fetch address
req_ready_i  in  1  memory accepts request
rsp_valid_i  in  1  in-order response valid (always accepted)
rsp_data_i  in  DATA_W  response instruction
inst_valid_o  out  1  FIFO head valid to decode
inst_ready_i  in  1  decode consumes head
inst_o  out  DATA_W  head instruction
pc_o  out  ADDR_W  head pc
next_taken_o  out  1  head predicted-taken bit
branch_slot_end_o  out  1  head is first instruction after a redirect
stall_req_o  out  1  fetch has nothing for decode
bp_pc_o  out  ADDR_W  current fetch pc to bp (IFU_BP_EN only)
bp_next_pc_i  in  ADDR_W  predicted next pc (IFU_BP_EN only)
bp_taken_i  in  1  prediction taken (IFU_BP_EN only)

Behaviour:
- Reset (n_rst_i low, async): fetch_pc=REBOOT_ADDR, FIFO and meta queue empty, outstanding=0, drop_cnt=0, started=0; all outputs 0 (req_addr_o=REBOOT_ADDR). started sets on the first clock after release, so req_valid_o stays low one cycle after release.
- Credit: req_valid_o = started & !flush_i & !branch_redirect_i & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count < FIFO_DEPTH). Every accepted request therefore owns a FIFO slot; FIFO write-on-full is a fatal assertion.
- A request counts only on req_valid_o & req_ready_i. There is no hold requirement: the request may be withdrawn; memory must not latch a non-handshaked request. On handshake: fetch_pc advances to fetch_pc+4 (ADDR_W wrap-around permitted); {pc, taken, slot_end} is pushed into the meta queue; outstanding increments.
- Response: pops the meta queue; outstanding decrements. If drop_cnt>0, the response is discarded and drop_cnt decrements. Otherwise {data, meta} is written to the FIFO. Latency from rsp_valid_i to inst_valid_o is 1 cycle when the FIFO was empty.
- Simultaneous handshake and response in the same cycle: outstanding is unchanged.
- Flush (cycle N): fetch_pc<=new_pc_i; FIFO and meta queue cleared; drop_cnt<=outstanding minus any non-dropped response in cycle N (plus current drop_cnt); outstanding<=drop_cnt'. Requests resume at new_pc_i in N+1; branch_slot_end for that stream is 0.
- Redirect (cycle N, no flush): same clearing, target branch_redirect_pc_i; the first request issued after it carries slot_end=1; all later requests carry 0.
- Flush and redirect together: flush wins.
- Decode handshake: a pop occurs on inst_valid_o & inst_ready_i. Push and pop in the same cycle are legal when full or empty (write-then-read bypass is not used).
- stall_req_o = started & (fifo_count==0).

Optional Feature:
IFU_BP_EN. When defined: bp_pc_o=fetch_pc; on handshake, fetch_pc<=bp_next_pc_i and taken=bp_taken_i is stored in the meta queue. When not defined: bp ports are absent, fetch_pc<=fetch_pc+4, and next_taken_o is always 0.

Decomposition:
- Shared package/defines.v: REBOOT_ADDR default, the instruction step constant 4, and the meta entry field layout {pc, taken, slot_end}.
- One sub-module, ifu_sync_fifo (parametrised width/depth, flush port, count output), instantiated twice: once as the meta queue and once as the prefetch FIFO.

Test Plan:
- Reset release with memory ready=1 and 1-cycle latency: addresses 0x0, 0x4, 0x8 issued back-to-back from cycle 2; inst_valid_o with pc_o=0x0 one cycle after the first response; stall_req_o drops.
- inst_ready_i=0 held: exactly FIFO_DEPTH=4 requests accepted, then req_valid_o stays low; the FIFO holds pcs 0x0..0xC; no overflow assertion.
- 3-cycle memory latency, 2 requests in flight, flush to 0x100: both old responses dropped; next delivered pc_o=0x100 with branch_slot_end_o=0.
- Redirect to 0x200 in the same cycle as a response arrives: that response is dropped; the first delivered instruction has pc_o=0x200 and branch_slot_end_o=1, the next 0x204 with 0.
- flush_i and branch_redirect_i asserted together (0x300 vs 0x400): fetch resumes at 0x300.
- IFU_BP_EN with bp_next_pc_i=0x80, bp_taken_i=1 at pc 0x10: the next request is 0x80; the instruction at 0x10 is delivered with next_taken_o=1.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and meta-queue entry layout for the instruction prefetch unit.
package ifu_prefetch_pkg;

  localparam int unsigned INST_STEP        = 4;
  localparam logic [31:0] REBOOT_ADDR_DFLT = 32'h0000_0000;

  // Per-request flags stored below the pc: meta entry is {pc, taken, slot_end}
  typedef struct packed {
    logic taken;
    logic slot_end;
  } meta_flags_t;

  localparam int unsigned META_FLAG_W = $bits(meta_flags_t);

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear that overrides push/pop.
module ifu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_o == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_o != '0);
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem[rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      count_o <= count_o + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  overflow_a : assert property (@(posedge clk_i) disable iff (!n_rst_i)
    !(push_i && full && !do_pop && !flush_i))
    else $fatal(1, "ifu_sync_fifo: push while full");

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: credit-limited fetch requests, in-order response tracking, prefetch buffer to decode.
// Branch-predictor hookup is compiled in with `define IFU_BP_EN.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       FIFO_DEPTH      = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] REBOOT_ADDR     = ADDR_W'(REBOOT_ADDR_DFLT)
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_redirect_i,
  input  logic [ADDR_W-1:0] branch_redirect_pc_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              next_taken_o,
  output logic              branch_slot_end_o,
`ifdef IFU_BP_EN
  output logic [ADDR_W-1:0] bp_pc_o,
  input  logic [ADDR_W-1:0] bp_next_pc_i,
  input  logic              bp_taken_i,
`endif
  output logic              stall_req_o
);

  localparam int unsigned CNT_W    = cnt_w(FIFO_DEPTH);
  localparam int unsigned MQ_CNT_W = cnt_w(MAX_OUTSTANDING);
  localparam int unsigned SUM_W    = CNT_W + 1;
  localparam int unsigned META_W   = ADDR_W + META_FLAG_W;
  localparam int unsigned ENTRY_W  = DATA_W + META_W;

  logic                started;
  logic                slot_pending;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   step_pc;
  logic [CNT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    drop_cnt;
  logic [CNT_W-1:0]    flush_outstanding;
  logic [CNT_W-1:0]    fifo_count;
  logic [MQ_CNT_W-1:0] mq_count;
  logic                clear;
  logic                req_hs;
  logic                rsp_drop;
  logic                rsp_keep;
  logic                pred_taken;
  meta_flags_t         push_flags;
  meta_flags_t         head_flags;
  logic [META_W-1:0]   mq_wdata;
  logic [META_W-1:0]   mq_rdata;
  logic [ENTRY_W-1:0]  pf_wdata;
  logic [ENTRY_W-1:0]  pf_rdata;

`ifdef IFU_BP_EN
  assign bp_pc_o    = fetch_pc;
  assign step_pc    = bp_next_pc_i;
  assign pred_taken = bp_taken_i;
`else
  assign step_pc    = fetch_pc + ADDR_W'(INST_STEP);
  assign pred_taken = 1'b0;
`endif

  assign clear = flush_i || branch_redirect_i;

  // Each accepted request reserves a prefetch slot, so the buffer can never overflow
  assign req_valid_o = started && !clear
                    && (outstanding < CNT_W'(MAX_OUTSTANDING))
                    && ((SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
  assign req_addr_o  = fetch_pc;
  assign req_hs      = req_valid_o && req_ready_i;

  // Responses to requests issued before a flush/redirect arrive first and are discarded
  assign rsp_drop = rsp_valid_i && (drop_cnt != '0);
  assign rsp_keep = rsp_valid_i && (drop_cnt == '0) && (mq_count != '0);

  assign flush_outstanding = (rsp_valid_i && (outstanding != '0)) ? outstanding - CNT_W'(1)
                                                                  : outstanding;

  always_comb begin
    push_flags          = '0;
    push_flags.taken    = pred_taken;
    push_flags.slot_end = slot_pending;
  end

  assign mq_wdata = {fetch_pc, push_flags};
  assign pf_wdata = {rsp_data_i, mq_rdata};

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      started      <= 1'b0;
      fetch_pc     <= REBOOT_ADDR;
      outstanding  <= '0;
      drop_cnt     <= '0;
      slot_pending <= 1'b0;
    end else begin
      started <= 1'b1;
      if (clear) begin
        fetch_pc     <= flush_i ? new_pc_i : branch_redirect_pc_i;
        slot_pending <= !flush_i;
        outstanding  <= flush_outstanding;
        drop_cnt     <= flush_outstanding;
      end else begin
        if (req_hs) begin
          fetch_pc     <= step_pc;
          slot_pending <= 1'b0;
        end
        outstanding <= outstanding + CNT_W'(req_hs) - CNT_W'(rsp_valid_i);
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
      end
    end
  end

  ifu_sync_fifo #(
    .WIDTH (META_W),
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (MQ_CNT_W)
  ) u_meta_q (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .flush_i (clear),
    .push_i  (req_hs),
    .data_i  (mq_wdata),
    .pop_i   (rsp_keep),
    .data_o  (mq_rdata),
    .count_o (mq_count)
  );

  ifu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_pf_fifo (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .flush_i (clear),
    .push_i  (rsp_keep),
    .data_i  (pf_wdata),
    .pop_i   (inst_ready_i),
    .data_o  (pf_rdata),
    .count_o (fifo_count)
  );

  assign inst_o            = pf_rdata[ENTRY_W-1 -: DATA_W];
  assign pc_o              = pf_rdata[META_W-1 -: ADDR_W];
  assign head_flags        = meta_flags_t'(pf_rdata[META_FLAG_W-1:0]);
  assign next_taken_o      = head_flags.taken;
  assign branch_slot_end_o = head_flags.slot_end;
  assign inst_valid_o      = (fifo_count != '0);
  assign stall_req_o       = started && (fifo_count == '0);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a variable-latency in-order memory model and decode monitor.
module tb_ifu_prefetch;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              n_rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic [ADDR_W-1:0] new_pc_i = '0;
  logic              branch_redirect_i = 1'b0;
  logic [ADDR_W-1:0] branch_redirect_pc_i = '0;
  logic              req_valid_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic              req_ready_i = 1'b1;
  logic              rsp_valid_i = 1'b0;
  logic [DATA_W-1:0] rsp_data_i = '0;
  logic              inst_valid_o;
  logic              inst_ready_i = 1'b1;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              next_taken_o;
  logic              branch_slot_end_o;
  logic              stall_req_o;
`ifdef IFU_BP_EN
  logic [ADDR_W-1:0] bp_pc_o;
  logic [ADDR_W-1:0] bp_next_pc_i;
  logic              bp_taken_i;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mem_lat = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] iss_q[$];
  logic [31:0] dlv_pc_q[$];
  logic [31:0] dlv_inst_q[$];
  logic        dlv_slot_q[$];
  logic        dlv_taken_q[$];

  ifu_prefetch dut (
    .clk_i                (clk_i),
    .n_rst_i              (n_rst_i),
    .flush_i              (flush_i),
    .new_pc_i             (new_pc_i),
    .branch_redirect_i    (branch_redirect_i),
    .branch_redirect_pc_i (branch_redirect_pc_i),
    .req_valid_o          (req_valid_o),
    .req_addr_o           (req_addr_o),
    .req_ready_i          (req_ready_i),
    .rsp_valid_i          (rsp_valid_i),
    .rsp_data_i           (rsp_data_i),
    .inst_valid_o         (inst_valid_o),
    .inst_ready_i         (inst_ready_i),
    .inst_o               (inst_o),
    .pc_o                 (pc_o),
    .next_taken_o         (next_taken_o),
    .branch_slot_end_o    (branch_slot_end_o),
`ifdef IFU_BP_EN
    .bp_pc_o              (bp_pc_o),
    .bp_next_pc_i         (bp_next_pc_i),
    .bp_taken_i           (bp_taken_i),
`endif
    .stall_req_o          (stall_req_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef IFU_BP_EN
  // Predictor stub: only pc 0x10 is predicted taken, to 0x80
  always_comb begin
    bp_next_pc_i = (bp_pc_o == 32'h10) ? 32'h80 : bp_pc_o + 32'd4;
    bp_taken_i   = (bp_pc_o == 32'h10);
  end
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  // Memory: request handshaken in cycle k answers during cycle k+mem_lat, in order
  always @(negedge clk_i) begin
    if (n_rst_i && req_valid_o && req_ready_i) begin
      mq_addr.push_back(req_addr_o);
      mq_due.push_back(cyc + mem_lat);
      iss_q.push_back(req_addr_o);
    end
    if (n_rst_i && inst_valid_o && inst_ready_i) begin
      dlv_pc_q.push_back(pc_o);
      dlv_inst_q.push_back(inst_o);
      dlv_slot_q.push_back(branch_slot_end_o);
      dlv_taken_q.push_back(next_taken_o);
    end
  end

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    rsp_valid_i = 1'b0;
    rsp_data_i  = '0;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] iss(input int i);
    if (i < iss_q.size()) return iss_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dlv_pc(input int i);
    if (i < dlv_pc_q.size()) return dlv_pc_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dlv_inst(input int i);
    if (i < dlv_inst_q.size()) return dlv_inst_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [1:0] dlv_slot(input int i);
    if (i < dlv_slot_q.size()) return {1'b0, dlv_slot_q[i]};
    return 2'b11;
  endfunction

  function automatic logic [1:0] dlv_taken(input int i);
    if (i < dlv_taken_q.size()) return {1'b0, dlv_taken_q[i]};
    return 2'b11;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset(input int lat);
    n_rst_i              = 1'b0;
    flush_i              = 1'b0;
    new_pc_i             = '0;
    branch_redirect_i    = 1'b0;
    branch_redirect_pc_i = '0;
    req_ready_i          = 1'b1;
    inst_ready_i         = 1'b1;
    mem_lat              = lat;
    mq_addr.delete();
    mq_due.delete();
    iss_q.delete();
    dlv_pc_q.delete();
    dlv_inst_q.delete();
    dlv_slot_q.delete();
    dlv_taken_q.delete();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Reset values, then back-to-back fetch with 1-cycle memory
    do_reset(1);
    check_eq("rst_req_valid", req_valid_o, 0);
    check_eq("rst_req_addr", req_addr_o, 32'h0);
    check_eq("rst_inst_valid", inst_valid_o, 0);
    check_eq("rst_stall", stall_req_o, 0);
    check_eq("rst_pc", pc_o, 32'h0);
    n_rst_i = 1'b1;
    #1;
    check_eq("s1_req_low_after_release", req_valid_o, 0);
    step();
    check_eq("s1_req_valid", req_valid_o, 1);
    check_eq("s1_req_addr0", req_addr_o, 32'h0);
    check_eq("s1_stall_empty", stall_req_o, 1);
    step();
    check_eq("s1_req_addr1", req_addr_o, 32'h4);
    check_eq("s1_no_inst_yet", inst_valid_o, 0);
    step();
    check_eq("s1_inst_valid", inst_valid_o, 1);
    check_eq("s1_head_pc", pc_o, 32'h0);
    check_eq("s1_head_inst", inst_o, mem_word(32'h0));
    check_eq("s1_stall_drop", stall_req_o, 0);
    repeat (6) step();
    check_eq("s1_iss0", iss(0), 32'h0);
    check_eq("s1_iss1", iss(1), 32'h4);
    check_eq("s1_iss2", iss(2), 32'h8);
    check_eq("s1_dlv1_pc", dlv_pc(1), 32'h4);
    check_eq("s1_dlv0_taken", dlv_taken(0), 0);

    // Decode stalled: fill exactly FIFO_DEPTH entries
    do_reset(1);
    inst_ready_i = 1'b0;
    n_rst_i = 1'b1;
    repeat (12) step();
    check_eq("s2_issued_cnt", iss_q.size(), 4);
    check_eq("s2_req_blocked", req_valid_o, 0);
    check_eq("s2_head_pc", pc_o, 32'h0);
    check_eq("s2_stall", stall_req_o, 0);
    inst_ready_i = 1'b1;
    repeat (4) step();
    check_eq("s2_dlv0", dlv_pc(0), 32'h0);
    check_eq("s2_dlv1", dlv_pc(1), 32'h4);
    check_eq("s2_dlv2", dlv_pc(2), 32'h8);
    check_eq("s2_dlv3", dlv_pc(3), 32'hC);
    check_eq("s2_dlv3_inst", dlv_inst(3), mem_word(32'hC));

    // Flush with two 3-cycle requests in flight
    do_reset(3);
    n_rst_i = 1'b1;
    for (int i = 0; i < 20 && iss_q.size() < 2; i++) step();
    check_eq("s3_two_inflight", iss_q.size(), 2);
    check_eq("s3_credit_full", req_valid_o, 0);
    flush_i  = 1'b1;
    new_pc_i = 32'h100;
    step();
    flush_i = 1'b0;
    check_eq("s3_flush_addr", req_addr_o, 32'h100);
    check_eq("s3_wait_drops", req_valid_o, 0);
    repeat (12) step();
    check_eq("s3_dlv0_pc", dlv_pc(0), 32'h100);
    check_eq("s3_dlv0_slot", dlv_slot(0), 0);
    check_eq("s3_dlv0_inst", dlv_inst(0), mem_word(32'h100));
    check_eq("s3_dlv1_pc", dlv_pc(1), 32'h104);

    // Redirect in the same cycle a response arrives
    do_reset(1);
    n_rst_i = 1'b1;
    for (int i = 0; i < 20 && !rsp_valid_i; i++) step();
    check_eq("s4_rsp_wait", rsp_valid_i, 1);
    branch_redirect_i    = 1'b1;
    branch_redirect_pc_i = 32'h200;
    #1;
    check_eq("s4_req_suppressed", req_valid_o, 0);
    step();
    branch_redirect_i = 1'b0;
    check_eq("s4_redirect_addr", req_addr_o, 32'h200);
    repeat (8) step();
    check_eq("s4_dlv0_pc", dlv_pc(0), 32'h200);
    check_eq("s4_dlv0_slot", dlv_slot(0), 1);
    check_eq("s4_dlv1_pc", dlv_pc(1), 32'h204);
    check_eq("s4_dlv1_slot", dlv_slot(1), 0);

    // Flush and redirect together: flush target wins
    do_reset(1);
    n_rst_i = 1'b1;
    for (int i = 0; i < 20 && !req_valid_o; i++) step();
    check_eq("s5_req_wait", req_valid_o, 1);
    flush_i              = 1'b1;
    new_pc_i             = 32'h300;
    branch_redirect_i    = 1'b1;
    branch_redirect_pc_i = 32'h400;
    step();
    flush_i           = 1'b0;
    branch_redirect_i = 1'b0;
    check_eq("s5_resume_addr", req_addr_o, 32'h300);
    repeat (6) step();
    check_eq("s5_dlv0_pc", dlv_pc(0), 32'h300);
    check_eq("s5_dlv0_slot", dlv_slot(0), 0);

`ifdef IFU_BP_EN
    // Predicted-taken at 0x10 steers the next request to 0x80
    do_reset(1);
    n_rst_i = 1'b1;
    #1;
    check_eq("bp_pc_reset", bp_pc_o, 32'h0);
    repeat (16) step();
    check_eq("bp_iss4", iss(4), 32'h10);
    check_eq("bp_iss5", iss(5), 32'h80);
    check_eq("bp_dlv4_taken", dlv_taken(4), 1);
    check_eq("bp_dlv3_taken", dlv_taken(3), 0);
    check_eq("bp_dlv5_pc", dlv_pc(5), 32'h80);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
